bit8_to_trit5_unpacker: RTL and testbench

- Sequential unpacker for packed S3 polynomials in the NTRU-HRSS KEM datapath. It is the inverse of the 5-trits-into-1-byte packer.
- Accepts bytes on a valid/ready stream. Each byte is a base-3 number t0 + 3·t1 + 9·t2 + 27·t3 + 81·t4 with value 0..242.
- Emits one trit per cycle, least-significant digit first, on a second valid/ready stream.
- Feeds the decapsulation-side polynomial loaders. Flags malformed encodings.

---
 rtl/ntru_pkg.sv | 17 +
 rtl/div3_u8.sv | 13 +
 rtl/bit8_to_trit5_unpacker.sv | 144 ++++++++++++++
 tb/tb_bit8_to_trit5_unpacker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntru_pkg.sv
// Shared types and constants for the NTRU-HRSS S3 trit unpacking datapath.
package ntru_pkg;

  localparam int N_TRITS_DEFAULT = 700;
  localparam int TRITS_PER_BYTE  = 5;
  localparam int MAX_PACKED_BYTE = 242;

  typedef logic [1:0] trit_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    DONE
  } unpack_state_t;

endpackage

// File: rtl/div3_u8.sv
// Combinational 8-bit divide-by-3 with remainder.
// floor(x*171/512) equals floor(x/3) for every 8-bit x, so the quotient is a
// single constant multiply and shift; the remainder is x - 3*q.
module div3_u8 (
  input  logic [7:0] dividend,
  output logic [6:0] quotient,
  output logic [1:0] remainder
);

  assign quotient  = 7'((16'(dividend) * 16'd171) >> 9);
  assign remainder = 2'(dividend - ({1'b0, quotient} + {quotient, 1'b0}));

endmodule

// File: rtl/bit8_to_trit5_unpacker.sv
// Unpacks base-3 packed bytes (5 trits per byte, LSD first) into a trit
// stream for the decapsulation-side polynomial loaders. Malformed encodings
// (byte > 242, or non-zero unused digits in the final partial byte) set a
// sticky err flag that only start clears.
//
// state | meaning
// IDLE  | waiting for start after reset
// LOAD  | waiting for the next packed byte
// EMIT  | presenting v mod 3; reloads back-to-back at the byte boundary
// DONE  | all N_TRITS trits delivered; waits for start
module bit8_to_trit5_unpacker
  import ntru_pkg::*;
#(
  parameter int N_TRITS = N_TRITS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] out_trit,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_W = $clog2(N_TRITS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TRITS - 1);
  localparam logic [2:0] LAST_DIG = 3'(TRITS_PER_BYTE - 1);

  unpack_state_t    state, state_nxt;
  logic [7:0]       v, v_nxt;
  logic [2:0]       dig_cnt, dig_nxt;
  logic [CNT_W-1:0] trit_cnt, trit_nxt;
  logic             err_nxt;

  logic [6:0] q;
  trit_t      r;
  logic       is_last;
  logic       is_bnd;
  logic       bad_byte;

  div3_u8 u_div3 (
    .dividend  (v),
    .quotient  (q),
    .remainder (r)
  );

  // Next-state, datapath update and handshake outputs; start overrides all.
  always_comb begin
    state_nxt = state;
    v_nxt     = v;
    dig_nxt   = dig_cnt;
    trit_nxt  = trit_cnt;
    err_nxt   = err;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_trit  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    is_last   = (trit_cnt == LAST_IDX);
    is_bnd    = (dig_cnt == LAST_DIG);
    bad_byte  = (in_byte > 8'(MAX_PACKED_BYTE));

    case (state)
      IDLE: begin
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          v_nxt     = in_byte;
          dig_nxt   = '0;
          state_nxt = EMIT;
          if (bad_byte) err_nxt = 1'b1;
        end
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_trit  = r;
        out_last  = is_last;
        // zero-bubble reload: take the next byte in the same cycle the
        // fifth digit leaves, but only when the consumer is taking it
        if (is_bnd && !is_last) in_ready = out_ready;
        if (out_ready) begin
          v_nxt    = {1'b0, q};
          dig_nxt  = dig_cnt + 3'd1;
          trit_nxt = trit_cnt + CNT_W'(1);
          // leftover high digits mean the byte was not a valid encoding
          if ((is_last || is_bnd) && (q != '0)) err_nxt = 1'b1;
          if (is_last) begin
            state_nxt = DONE;
          end else if (is_bnd) begin
            if (in_valid) begin
              v_nxt   = in_byte;
              dig_nxt = '0;
              if (bad_byte) err_nxt = 1'b1;
            end else begin
              state_nxt = LOAD;
            end
          end
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (start) begin
      state_nxt = LOAD;
      v_nxt     = '0;
      dig_nxt   = '0;
      trit_nxt  = '0;
      err_nxt   = 1'b0;
    end
  end

  // State, value and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      v        <= '0;
      dig_cnt  <= '0;
      trit_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      v        <= v_nxt;
      dig_cnt  <= dig_nxt;
      trit_cnt <= trit_nxt;
      err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bit8_to_trit5_unpacker.sv
// Directed bench for bit8_to_trit5_unpacker: one instance with the full
// 700-trit polynomial and one with N_TRITS=7 for partial-last-byte cases.
// Expected trits are pushed to a queue when bytes are queued and popped on
// each observed output transfer.
module tb_bit8_to_trit5_unpacker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic       in_valid, out_ready;
  logic [7:0] in_byte;

  logic       ir_a, ov_a, ol_a, bz_a, dn_a, er_a;
  logic [1:0] ot_a;
  logic       ir_b, ov_b, ol_b, bz_b, dn_b, er_b;
  logic [1:0] ot_b;

  logic       sel;
  logic       cur_ir, cur_ov, cur_ol, cur_bz, cur_dn, cur_er;
  logic [1:0] cur_ot;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] bq[$];
  logic [2:0] exp_q[$];
  int   next_idx, trits_done, pending, cyc;
  int   first_byte_cyc, first_pop_cyc, last_pop_cyc;
  logic active, exp_err, bp_en, gap_en, prev_stall, prev_ol;
  logic [1:0] prev_ot;

  // free-running clock
  always #5 clk = ~clk;

  bit8_to_trit5_unpacker #(.N_TRITS(700)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(ir_a), .out_valid(ov_a), .out_trit(ot_a), .out_ready(out_ready),
    .out_last(ol_a), .busy(bz_a), .done(dn_a), .err(er_a)
  );

  bit8_to_trit5_unpacker #(.N_TRITS(7)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(ir_b), .out_valid(ov_b), .out_trit(ot_b), .out_ready(out_ready),
    .out_last(ol_b), .busy(bz_b), .done(dn_b), .err(er_b)
  );

  assign cur_ir = sel ? ir_b : ir_a;
  assign cur_ov = sel ? ov_b : ov_a;
  assign cur_ot = sel ? ot_b : ot_a;
  assign cur_ol = sel ? ol_b : ol_a;
  assign cur_bz = sel ? bz_b : bz_a;
  assign cur_dn = sel ? dn_b : dn_a;
  assign cur_er = sel ? er_b : er_a;

  function automatic int n_cur();
    return sel ? 7 : 700;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic reset_model(input logic act);
    bq.delete();
    exp_q.delete();
    next_idx   = 0;
    trits_done = 0;
    pending    = 0;
    exp_err    = 1'b0;
    prev_stall = 1'b0;
    active     = act;
  endtask

  // queue a byte and the trits a base-3 reference decode says it yields
  task automatic push_byte(input logic [7:0] b);
    int n;
    int v;
    n = n_cur() - next_idx;
    if (n > 5) n = 5;
    v = int'(b);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({(next_idx + k == n_cur() - 1), 2'(v % 3)});
      v = v / 3;
    end
    if (v != 0) exp_err = 1'b1;
    next_idx += n;
    bq.push_back(b);
  endtask

  // one clock: drive after the edge, sample and score at the falling edge
  task automatic tick(input logic strt);
    logic [2:0] e;
    logic exp_ir, ixf, oxf;
    start_a   = strt && !sel;
    start_b   = strt && sel;
    in_valid  = (bq.size() != 0) && (!gap_en || $urandom_range(0, 3) != 0);
    in_byte   = (bq.size() != 0) ? bq[0] : 8'h00;
    out_ready = !bp_en || ($urandom_range(0, 1) == 1);
    @(negedge clk);
    if (!strt) begin
      if (prev_stall && cur_ov) begin
        chk("stall_trit", 32'(cur_ot), 32'(prev_ot));
        chk("stall_last", 32'(cur_ol), 32'(prev_ol));
      end
      exp_ir = active && (pending == 0 ||
               (pending == 1 && trits_done != n_cur() - 1 && out_ready));
      chk("in_ready", 32'(cur_ir), 32'(exp_ir));
      ixf = in_valid && cur_ir;
      oxf = cur_ov && out_ready;
      if (oxf) begin
        if (exp_q.size() == 0) begin
          chk("extra_trit", 32'(cur_ov), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("trit", 32'(cur_ot), 32'(e[1:0]));
          chk("last", 32'(cur_ol), 32'(e[2]));
          trits_done++;
          pending--;
          if (trits_done == 1) first_pop_cyc = cyc;
          last_pop_cyc = cyc;
          if (e[2]) active = 1'b0;
        end
      end
      if (ixf) begin
        void'(bq.pop_front());
        if (trits_done == 0) first_byte_cyc = cyc;
        pending = n_cur() - trits_done;
        if (pending > 5) pending = 5;
      end
      prev_stall = cur_ov && !out_ready;
      prev_ot    = cur_ot;
      prev_ol    = cur_ol;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    cyc++;
  endtask

  task automatic do_start();
    tick(1'b1);
    reset_model(1'b1);
  endtask

  task automatic run_all(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1'b0);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // time bound in case a handshake never completes
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // directed sequence
  initial begin
    rst = 1'b1; sel = 1'b0; start_a = 1'b0; start_b = 1'b0;
    in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
    bp_en = 1'b0; gap_en = 1'b0; cyc = 0;
    first_byte_cyc = 0; first_pop_cyc = 0; last_pop_cyc = 0;
    prev_ot = 2'b00; prev_ol = 1'b0;
    reset_model(1'b0);
    #2 rst = 1'b0;
    #1;
    chk("rst_outs_a", 32'({ir_a, ov_a, ot_a, ol_a, bz_a, dn_a, er_a}), 32'd0);
    chk("rst_outs_b", 32'({ir_b, ov_b, ot_b, ol_b, bz_b, dn_b, er_b}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(cur_bz), 32'd0);

    // known bytes 0xF2, 0x00, 0x2E
    do_start();
    chk("start_busy", 32'(cur_bz), 32'd1);
    chk("start_err", 32'(cur_er), 32'd0);
    push_byte(8'hF2);
    push_byte(8'h00);
    push_byte(8'h2E);
    run_all(100);
    chk("known_err", 32'(cur_er), 32'd0);
    chk("known_done", 32'(cur_dn), 32'd0);

    // 140 random bytes streamed back-to-back
    do_start();
    for (int i = 0; i < 140; i++) push_byte(8'($urandom_range(0, 242)));
    run_all(1000);
    chk("stream_span", 32'(last_pop_cyc - first_pop_cyc), 32'd699);
    chk("first_latency", 32'(first_pop_cyc - first_byte_cyc), 32'd1);
    chk("stream_done", 32'(cur_dn), 32'd1);
    chk("stream_busy", 32'(cur_bz), 32'd0);
    chk("stream_ov", 32'(cur_ov), 32'd0);
    chk("stream_err", 32'(cur_er), 32'(exp_err));

    // random backpressure and input gaps
    bp_en = 1'b1;
    gap_en = 1'b1;
    do_start();
    for (int i = 0; i < 140; i++) push_byte(8'($urandom_range(0, 242)));
    run_all(8000);
    chk("bp_done", 32'(cur_dn), 32'd1);
    chk("bp_err", 32'(cur_er), 32'(exp_err));
    bp_en = 1'b0;
    gap_en = 1'b0;

    // out-of-range byte: sticky err until start
    do_start();
    push_byte(8'd243);
    run_all(50);
    chk("b243_err", 32'(cur_er), 32'd1);
    push_byte(8'h05);
    run_all(50);
    chk("b243_sticky", 32'(cur_er), 32'd1);
    do_start();
    chk("b243_cleared", 32'(cur_er), 32'd0);

    // async reset in the middle of EMIT
    push_byte(8'hF2);
    repeat (3) tick(1'b0);
    chk("pre_rst_ov", 32'(cur_ov), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_outs_a", 32'({ir_a, ov_a, ot_a, ol_a, bz_a, dn_a, er_a}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    reset_model(1'b0);
    chk("postrst_busy", 32'(cur_bz), 32'd0);

    // N_TRITS=7, clean partial last byte
    sel = 1'b1;
    do_start();
    push_byte(8'h05);
    push_byte(8'h05);
    run_all(50);
    chk("n7_done", 32'(cur_dn), 32'd1);
    chk("n7_err", 32'(cur_er), 32'd0);

    // N_TRITS=7, residual digit in partial last byte
    do_start();
    push_byte(8'h05);
    push_byte(8'h0E);
    run_all(50);
    chk("n7res_done", 32'(cur_dn), 32'd1);
    chk("n7res_err", 32'(cur_er), 32'(exp_err));

    // start in the middle of EMIT drops the pending trit and clears err
    do_start();
    push_byte(8'd243);
    repeat (3) tick(1'b0);
    chk("abort_pre_err", 32'(cur_er), 32'd1);
    do_start();
    chk("abort_ov", 32'(cur_ov), 32'd0);
    chk("abort_err", 32'(cur_er), 32'd0);
    chk("abort_busy", 32'(cur_bz), 32'd1);
    push_byte(8'h05);
    push_byte(8'h05);
    run_all(50);
    chk("abort_done", 32'(cur_dn), 32'd1);
    chk("abort_final_err", 32'(cur_er), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
